quant_pipe_mc: RTL
==================

QUANT_PIPE_MC -- requirements
Module: quant_pipe_mc

Interface
REQ-001: Parameter DATA_W, default 32, sample width; signed fixed point.
REQ-002: Parameter FRAC_W, default 16, fraction bits (Q16.16 at defaults); no rescaling is performed, kept for documentation/checks.
REQ-003: Parameter CHANNELS, default 4, independent channel count; SHALL be a power of two, >=2; CH_W = log2(CHANNELS).
REQ-004: Parameter ALPHA_SHIFT, default 3, EMA smoothing shift (alpha = 2^-ALPHA_SHIFT), range 1..8.
REQ-005: clk  input  1  sole clock; all state updates on rising edge.
REQ-006: rst  input  1  asynchronous, active-high reset.
REQ-007: cfg_bypass  input  1  1 = risk clamp disabled.
REQ-008: cfg_limit  input  DATA_W  signed clamp magnitude L.
REQ-009: in_valid  input  1; in_ready  output  1; in_chan  input  CH_W; in_data  input  DATA_W signed sample.
REQ-010: out_valid  output  1; out_ready  input  1; out_chan  output  CH_W; out_data  output  DATA_W signed result.
REQ-011: out_sat  output  1  result was clamped.
REQ-012: sat_count  output  16  count of clamped results delivered.

Function
REQ-013: Three registered stages S1 (feature), S2 (signal), S3 (risk); each holds valid, chan, and its data.
REQ-014: Stage k SHALL load when ready_k = !valid_k || ready_(k+1); ready_4 = out_ready; in_ready = ready_1 (combinational path from out_ready permitted).
REQ-015: Latency 3 cycles from input handshake to out_valid with no stall; throughput 1 sample/cycle.
REQ-016: While out_valid && !out_ready, out_data/out_chan/out_sat SHALL hold stable; no sample dropped, duplicated or reordered.
REQ-017: Per-channel state: ema[CHANNELS] (DATA_W) and init[CHANNELS] flag, updated only on input handshake.
REQ-018: S1 on handshake for channel c, sample x: if init[c]=0, ema_new = x and init[c] set; else ema_new = ema[c] + ((x - ema[c]) >>> ALPHA_SHIFT), computed in DATA_W+1 bits, saturated to DATA_W.
REQ-019: ema[c] written with ema_new in the same cycle; a back-to-back same-channel sample SHALL use the updated value.
REQ-020: S1 registers x and ema_new.
REQ-021: S2: sig = x - ema_new in DATA_W+1 bits, saturated to signed DATA_W min/max.
REQ-022: S3 load: L = cfg_limit if cfg_limit > 0 else 0; if cfg_bypass=0 and sig > L, result = L, sat = 1; if sig < -L, result = -L, sat = 1; else result = sig, sat = 0.
REQ-023: cfg_bypass=1 at S3 load: result = sig, sat = 0; cfg_bypass and cfg_limit are sampled only at S3 load.
REQ-024: sat_count increments on out_valid && out_ready && out_sat; saturates at 0xFFFF (no wrap).
REQ-025: Simultaneous S3 output handshake and S3 reload SHALL be supported without bubble.

Reset
REQ-026: On rst: all stage valids 0, out_valid 0, out_data 0, out_chan 0, out_sat 0, sat_count 0, all ema 0, all init 0.
REQ-027: in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-028: rst mid-stream discards all in-flight samples; the next sample per channel is treated as first (REQ-018).

Verification
REQ-029: ch0 x=0x0001_0000 after reset, out_ready=1 -> 3 cycles later out_valid=1, out_chan=0, out_data=0x0000_0000, out_sat=0.
REQ-030: then ch0 x=0x0009_0000, cfg_limit=0x0010_0000 -> ema=0x0002_0000, out_data=0x0007_0000, out_sat=0.
REQ-031: repeat REQ-030 sequence with cfg_limit=0x0004_0000 -> out_data=0x0004_0000, out_sat=1, sat_count=1; same with cfg_bypass=1 -> 0x0007_0000, out_sat=0, sat_count unchanged.
REQ-032: interleave ch1 x=0x0002_0000 and ch2 x=0xFFFE_0000 each first -> both outputs 0, ema independent of ch0; negative sig clamps to -L.
REQ-033: stream 8 samples, out_ready low 5 cycles -> in_ready drops after 3 further accepts, out_data held stable, all 8 delivered in order.
REQ-034: assert rst with 3 samples in flight -> out_valid=0 immediately, sat_count=0; next ch0 sample yields out_data=0.

Source files
------------

// File: rtl/quant_pipe_mc.sv
// quant_pipe_mc
//   Three-stage, multi-channel quantisation pipeline for signed fixed-point samples.
//   S1 (feature): per-channel EMA, alpha = 2^-ALPHA_SHIFT; the first sample after
//                 reset seeds the channel.
//   S2 (signal) : deviation of the sample from its EMA, saturated.
//   S3 (risk)   : symmetric clamp to +/-cfg_limit unless bypassed; counts clamps.
//   Each stage has valid/ready flow control, so a stalled output back-pressures
//   the whole pipe without dropping samples.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   cfg_bypass        1 = clamp disabled (sampled when S3 loads)
//   cfg_limit         signed clamp magnitude; values <= 0 act as 0
//   in_valid/in_ready input handshake; in_chan, in_data = channel and sample
//   out_valid/out_ready output handshake; out_chan, out_data = channel and result
//   out_sat           result was clamped
//   sat_count         clamped results delivered, saturating at 0xFFFF
module quant_pipe_mc #(
    parameter int DATA_W      = 32,
    parameter int FRAC_W      = 16,
    parameter int CHANNELS    = 4,
    parameter int ALPHA_SHIFT = 3,
    localparam int CH_W       = $clog2(CHANNELS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_bypass,
    input  logic signed [DATA_W-1:0] cfg_limit,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic        [CH_W-1:0]   in_chan,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic        [CH_W-1:0]   out_chan,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_sat,
    output logic        [15:0]       sat_count
);

    if ((CHANNELS < 2) || ((CHANNELS & (CHANNELS - 1)) != 0)) begin : g_bad_channels
        $error("CHANNELS must be a power of two and at least 2");
    end
    if ((ALPHA_SHIFT < 1) || (ALPHA_SHIFT > 8)) begin : g_bad_alpha
        $error("ALPHA_SHIFT must be in 1..8");
    end
    if ((FRAC_W < 0) || (FRAC_W >= DATA_W)) begin : g_bad_frac
        $error("FRAC_W must be in 0..DATA_W-1");
    end

    // Collapse a DATA_W+1 bit signed value into DATA_W bits, clipping at min/max.
    function automatic logic signed [DATA_W-1:0] sat_w(input logic signed [DATA_W:0] v);
        logic signed [DATA_W-1:0] r;
        if (v[DATA_W] != v[DATA_W-1]) begin
            r = v[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            r = v[DATA_W-1:0];
        end
        return r;
    endfunction

    // Per-channel EMA state
    logic signed [DATA_W-1:0] ema_q [CHANNELS];
    logic signed [DATA_W-1:0] ema_d [CHANNELS];
    logic [CHANNELS-1:0]      init_q, init_d;

    // Stage registers
    logic                     vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d, vld_p3_q, vld_p3_d;
    logic [CH_W-1:0]          chan_p1_q, chan_p1_d, chan_p2_q, chan_p2_d, chan_p3_q, chan_p3_d;
    logic signed [DATA_W-1:0] x_p1_q, x_p1_d, ema_p1_q, ema_p1_d;
    logic signed [DATA_W-1:0] sig_p2_q, sig_p2_d;
    logic signed [DATA_W-1:0] res_p3_q, res_p3_d;
    logic                     sat_p3_q, sat_p3_d;
    logic [15:0]              sat_cnt_q, sat_cnt_d;

    logic                     rdy_p1, rdy_p2, rdy_p3, in_fire;
    logic signed [DATA_W-1:0] ema_cur, ema_new, lim, neg_lim;
    logic signed [DATA_W:0]   diff_ext, step_ext, sum_ext;

    always_comb begin
        rdy_p3   = !vld_p3_q || out_ready;
        rdy_p2   = !vld_p2_q || rdy_p3;
        rdy_p1   = !vld_p1_q || rdy_p2;
        in_fire  = in_valid && rdy_p1;

        ema_cur  = ema_q[in_chan];
        diff_ext = {in_data[DATA_W-1], in_data} - {ema_cur[DATA_W-1], ema_cur};
        step_ext = diff_ext >>> ALPHA_SHIFT;
        sum_ext  = {ema_cur[DATA_W-1], ema_cur} + step_ext;
        ema_new  = init_q[in_chan] ? sat_w(sum_ext) : in_data;

        // A negative limit is treated as zero, so neg_lim never overflows.
        lim      = cfg_limit[DATA_W-1] ? {DATA_W{1'b0}} : cfg_limit;
        neg_lim  = -lim;

        ema_d    = ema_q;
        init_d   = init_q;
        if (in_fire) begin
            ema_d[in_chan]  = ema_new;
            init_d[in_chan] = 1'b1;
        end

        // S1 load
        vld_p1_d  = vld_p1_q;
        chan_p1_d = chan_p1_q;
        x_p1_d    = x_p1_q;
        ema_p1_d  = ema_p1_q;
        if (rdy_p1) begin
            vld_p1_d  = in_valid;
            chan_p1_d = in_chan;
            x_p1_d    = in_data;
            ema_p1_d  = ema_new;
        end

        // S2 load
        vld_p2_d  = vld_p2_q;
        chan_p2_d = chan_p2_q;
        sig_p2_d  = sig_p2_q;
        if (rdy_p2) begin
            vld_p2_d  = vld_p1_q;
            chan_p2_d = chan_p1_q;
            sig_p2_d  = sat_w({x_p1_q[DATA_W-1], x_p1_q} - {ema_p1_q[DATA_W-1], ema_p1_q});
        end

        // S3 load; config is only looked at here
        vld_p3_d  = vld_p3_q;
        chan_p3_d = chan_p3_q;
        res_p3_d  = res_p3_q;
        sat_p3_d  = sat_p3_q;
        if (rdy_p3) begin
            vld_p3_d  = vld_p2_q;
            chan_p3_d = chan_p2_q;
            res_p3_d  = sig_p2_q;
            sat_p3_d  = 1'b0;
            if (!cfg_bypass && (sig_p2_q > lim)) begin
                res_p3_d = lim;
                sat_p3_d = 1'b1;
            end else if (!cfg_bypass && (sig_p2_q < neg_lim)) begin
                res_p3_d = neg_lim;
                sat_p3_d = 1'b1;
            end
        end

        sat_cnt_d = sat_cnt_q;
        if (vld_p3_q && out_ready && sat_p3_q && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                ema_q[i] <= '0;
            end
            init_q    <= '0;
            vld_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
            vld_p3_q  <= 1'b0;
            chan_p3_q <= '0;
            res_p3_q  <= '0;
            sat_p3_q  <= 1'b0;
            sat_cnt_q <= '0;
        end else begin
            ema_q     <= ema_d;
            init_q    <= init_d;
            vld_p1_q  <= vld_p1_d;
            vld_p2_q  <= vld_p2_d;
            vld_p3_q  <= vld_p3_d;
            chan_p3_q <= chan_p3_d;
            res_p3_q  <= res_p3_d;
            sat_p3_q  <= sat_p3_d;
            sat_cnt_q <= sat_cnt_d;
        end
    end

    // Inner datapath registers are qualified by their valids and need no reset.
    always_ff @(posedge clk) begin
        chan_p1_q <= chan_p1_d;
        x_p1_q    <= x_p1_d;
        ema_p1_q  <= ema_p1_d;
        chan_p2_q <= chan_p2_d;
        sig_p2_q  <= sig_p2_d;
    end

    assign in_ready  = rdy_p1;
    assign out_valid = vld_p3_q;
    assign out_chan  = chan_p3_q;
    assign out_data  = res_p3_q;
    assign out_sat   = sat_p3_q;
    assign sat_count = sat_cnt_q;

endmodule
